phys_reg_free_list: RTL and testbench

Circular free list of physical register tags for the register-renaming stage. It sits directly upstream of the physical register file: rename pulls destination tags from it, and the file is later written at those tags. It takes back tags released at instruction commit. A retire pointer lets a pipeline flush reclaim every tag handed out since the last commit in one cycle.

---
 rtl/phys_reg_free_list_pkg.sv | 29 ++
 rtl/phys_tag_ring.sv | 48 ++++
 rtl/phys_reg_free_list.sv | 95 +++++++++
 tb/tb_phys_reg_free_list.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/phys_reg_free_list_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phys_reg_free_list_pkg
//  Description : Shared rename-stage constants and types (physical register
//                count, architectural register count, tag width, free-list
//                depth and pointer types).
//  Revision    : 1.0 - initial release
// ============================================================================
package phys_reg_free_list_pkg;

   localparam int NUM_PHYS = 64;
   localparam int NUM_ARCH = 32;
   localparam int PREG_W   = $clog2(NUM_PHYS);
   localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
   localparam int IDX_W    = $clog2(DEPTH);
   // One extra MSB acts as the wrap bit so full and empty are distinguishable
   localparam int PTR_W    = IDX_W + 1;

   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PTR_W-1:0]  ptr_t;
   typedef logic [IDX_W-1:0]  idx_t;

   // Conditional single-step pointer advance, wrapping modulo 2*DEPTH
   function automatic ptr_t ptr_incr(input ptr_t p, input logic en);
      return p + ptr_t'(en);
   endfunction

endpackage
`default_nettype wire

// File: rtl/phys_tag_ring.sv
`default_nettype none
// ============================================================================
//  Module      : phys_tag_ring
//  Description : Generic ring-buffer storage: one synchronous write port and
//                one asynchronous read port. Entry i resets to INIT_BASE+i.
//  Revision    : 1.0 - initial release
// ============================================================================
module phys_tag_ring #(
   parameter int WIDTH     = 6,
   parameter int DEPTH     = 32,
   parameter int INIT_BASE = 32,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_idx,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_idx,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Next-state of the storage: only the addressed slot changes on a write
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_idx] = wr_data;
      end
   end

   // Storage register; reset loads the initial ascending tag sequence
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= WIDTH'(INIT_BASE + i);
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/phys_reg_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : phys_reg_free_list
//  Description : Circular free list of physical register tags with head,
//                retire and tail pointers. Flush rewinds head to the retire
//                point so all uncommitted allocations are reclaimed at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module phys_reg_free_list
   import phys_reg_free_list_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              alloc_req,
   output logic              alloc_valid,
   output logic [PREG_W-1:0] alloc_phys_reg,
   input  logic              commit_alloc,
   input  logic              free_valid,
   input  logic [PREG_W-1:0] free_phys_reg,
   input  logic              flush,
   output logic [PREG_W-1:0] free_count,
   output logic              protocol_err
);

   ptr_t head_q, head_d;
   ptr_t retire_q, retire_d;
   ptr_t tail_q, tail_d;
   logic err_q, err_d;

   ptr_t w_avail;
   ptr_t w_occupied;
   logic w_alloc_fire;
   logic w_commit_ok;
   logic w_commit_err;
   logic w_store_full;
   logic w_free_ok;
   logic w_free_err;

   // Occupancy and per-operation legality, all from registered pointers
   always_comb begin
      w_avail      = tail_q - head_q;
      w_occupied   = tail_q - retire_q;
      w_alloc_fire = alloc_req && (w_avail != '0) && !flush;
      w_commit_ok  = commit_alloc && (retire_q != head_q);
      w_commit_err = commit_alloc && (retire_q == head_q);
      // Entries between retire and tail are either allocatable or still
      // speculatively held, so neither may be overwritten by a free
      w_store_full = (w_occupied == ptr_t'(DEPTH));
      w_free_ok    = free_valid && !w_store_full;
      w_free_err   = free_valid && w_store_full;
   end

   // Pointer next-state; flush rewinds head to the post-commit retire point
   always_comb begin
      retire_d = ptr_incr(retire_q, w_commit_ok);
      tail_d   = ptr_incr(tail_q, w_free_ok);
      head_d   = flush ? retire_d : ptr_incr(head_q, w_alloc_fire);
      err_d    = err_q || w_commit_err || w_free_err;
   end

   // Pointer and sticky error registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q   <= '0;
         retire_q <= '0;
         tail_q   <= ptr_t'(DEPTH);
         err_q    <= 1'b0;
      end else begin
         head_q   <= head_d;
         retire_q <= retire_d;
         tail_q   <= tail_d;
         err_q    <= err_d;
      end
   end

   phys_tag_ring #(
      .WIDTH     (PREG_W),
      .DEPTH     (DEPTH),
      .INIT_BASE (NUM_ARCH)
   ) u_ring (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (w_free_ok),
      .wr_idx  (tail_q[IDX_W-1:0]),
      .wr_data (free_phys_reg),
      .rd_idx  (head_q[IDX_W-1:0]),
      .rd_data (alloc_phys_reg)
   );

   assign alloc_valid  = (w_avail != '0);
   assign free_count   = PREG_W'(w_avail);
   assign protocol_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_phys_reg_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phys_reg_free_list
//  Description : Scoreboard bench for phys_reg_free_list. The reference model
//                keeps the allocatable tags and the uncommitted allocations as
//                two ordered queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phys_reg_free_list;

   localparam int DEPTH = 32;
   localparam int NARCH = 32;

   logic       clk;
   logic       reset;
   logic       alloc_req;
   logic       alloc_valid;
   logic [5:0] alloc_phys_reg;
   logic       commit_alloc;
   logic       free_valid;
   logic [5:0] free_phys_reg;
   logic       flush;
   logic [5:0] free_count;
   logic       protocol_err;

   phys_reg_free_list dut (
      .clk            (clk),
      .reset          (reset),
      .alloc_req      (alloc_req),
      .alloc_valid    (alloc_valid),
      .alloc_phys_reg (alloc_phys_reg),
      .commit_alloc   (commit_alloc),
      .free_valid     (free_valid),
      .free_phys_reg  (free_phys_reg),
      .flush          (flush),
      .free_count     (free_count),
      .protocol_err   (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [5:0] tag;
      logic [5:0] cnt;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   logic [5:0] avail[$];   // allocatable tags, oldest first
   logic [5:0] spec[$];    // allocated but uncommitted tags, oldest first
   logic       m_err;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      avail.delete();
      spec.delete();
      for (int i = 0; i < DEPTH; i++) avail.push_back(6'(NARCH + i));
      m_err = 1'b0;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.v   = (avail.size() != 0);
      e.tag = e.v ? avail[0] : 6'd0;
      e.cnt = 6'(avail.size());
      e.err = m_err;
      return e;
   endfunction

   // One clock edge worth of behaviour, judged on the state before the edge
   task automatic model_apply(input logic a, input logic c, input logic f,
                              input logic [5:0] t, input logic fl);
      int  n_av = avail.size();
      int  n_sp = spec.size();
      logic [5:0] x;
      if (a && n_av > 0 && !fl) begin
         x = avail.pop_front();
         spec.push_back(x);
      end
      if (c) begin
         if (n_sp > 0) x = spec.pop_front();
         else          m_err = 1'b1;
      end
      if (f) begin
         if (n_av + n_sp == DEPTH) m_err = 1'b1;
         else                      avail.push_back(t);
      end
      if (fl) begin
         for (int i = spec.size() - 1; i >= 0; i--) avail.push_front(spec[i]);
         spec.delete();
      end
   endtask

   // Issue one cycle: record what the DUT should show now, then drive inputs
   task automatic step(input logic a, input logic c, input logic f,
                       input logic [5:0] t, input logic fl);
      @(posedge clk);
      #1;
      exp_q.push_back(model_out());
      alloc_req     = a;
      commit_alloc  = c;
      free_valid    = f;
      free_phys_reg = t;
      flush         = fl;
      model_apply(a, c, f, t, fl);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
   endtask

   // Reset asserted between edges; outputs are checked before any clock edge
   task automatic async_reset();
      @(negedge clk);
      #1;
      reset         = 1'b0;
      alloc_req     = 1'b0;
      commit_alloc  = 1'b0;
      free_valid    = 1'b0;
      free_phys_reg = 6'd0;
      flush         = 1'b0;
      #1;
      chk("rst_alloc_valid", int'(alloc_valid), 1);
      chk("rst_alloc_tag", int'(alloc_phys_reg), NARCH);
      chk("rst_free_count", int'(free_count), DEPTH);
      chk("rst_protocol_err", int'(protocol_err), 0);
      model_reset();
      @(negedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic random_phase(input int n);
      logic a, c, f, fl;
      for (int k = 0; k < n; k++) begin
         a  = ($urandom_range(0, 99) < 60);
         c  = (spec.size() > 0) ? ($urandom_range(0, 99) < 50)
                                : ($urandom_range(0, 999) < 5);
         f  = (avail.size() + spec.size() == DEPTH) ? ($urandom_range(0, 999) < 5)
                                                    : ($urandom_range(0, 99) < 45);
         fl = ($urandom_range(0, 99) < 5);
         step(a, c, f, 6'($urandom_range(0, 63)), fl);
      end
   endtask

   // Monitor: compares every cycle for which an expectation was recorded
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("alloc_valid", int'(alloc_valid), int'(e.v));
            chk("free_count", int'(free_count), int'(e.cnt));
            chk("protocol_err", int'(protocol_err), int'(e.err));
            if (e.v) chk("alloc_phys_reg", int'(alloc_phys_reg), int'(e.tag));
         end
      end
   end

   initial begin
      reset         = 1'b1;
      alloc_req     = 1'b0;
      commit_alloc  = 1'b0;
      free_valid    = 1'b0;
      free_phys_reg = 6'd0;
      flush         = 1'b0;
      model_reset();
      #2;
      async_reset();

      // Drain the whole list in order, then observe empty
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
      idle();
      // Commit everything so storage has room, then free 40 while empty
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 6'd40, 1'b0);
      idle();
      step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
      idle();

      // Alloc three, commit one, flush, re-allocate the rewound tag
      async_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
      idle();

      // Flush with same-cycle commit and free of tag 5, then walk to tag 5
      async_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 6'd5, 1'b1);
      for (int i = 0; i < 31; i++) step(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
      idle();

      // Free while storage is full: dropped, sticky error
      async_reset();
      step(1'b0, 1'b0, 1'b1, 6'd7, 1'b0);
      for (int i = 0; i < 3; i++) idle();
      // Commit with nothing outstanding
      async_reset();
      step(1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
      idle();

      // Randomised traffic, with an asynchronous reset in the middle
      async_reset();
      random_phase(1500);
      async_reset();
      random_phase(1500);
      idle();
      idle();
      @(negedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
